rr_grant_scheduler: RTL

RR_GRANT_SCHEDULER -- requirements
Module: rr_grant_scheduler

---
 rtl/rr_grant_scheduler.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/rr_grant_scheduler.sv
// rr_grant_scheduler: round-robin single-grant arbiter with bounded hold time.
//
// A grant is issued from IDLE when en=1 and any req bit is set, choosing the
// first requester at or after the round-robin pointer. The grant is held until
// the owner pulses done, or until MAX_HOLD cycles elapse (timeout pulse).
// Every release returns to IDLE for at least one cycle, then the pointer moves
// one past the released owner.
//
// Ports:
//   clk      in   1        clock, all state on posedge
//   rst      in   1        synchronous active-high reset
//   en       in   1        arbitration enable (gates new grants only)
//   req      in   NUM_REQ  level request per requester
//   done     in   NUM_REQ  release pulse from the granted requester
//   gnt      out  NUM_REQ  one-hot grant (registered)
//   gnt_id   out  ID_W     index of granted requester, valid while busy
//   busy     out  1        a grant is active
//   timeout  out  1        one-cycle pulse when a grant is revoked at MAX_HOLD
module rr_grant_scheduler #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         done,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       busy,
  output logic                       timeout
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned SUM_W = ID_W + 1;
  localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t               r_state;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [ID_W-1:0]      r_gnt_id;
  logic                 r_busy;
  logic                 r_timeout;
  logic [CNT_W-1:0]     r_cnt;
  logic [ID_W-1:0]      r_ptr;

  state_t               w_state_nxt;
  logic [NUM_REQ-1:0]   w_gnt_nxt;
  logic [ID_W-1:0]      w_gnt_id_nxt;
  logic                 w_busy_nxt;
  logic                 w_timeout_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [ID_W-1:0]      w_ptr_nxt;

  logic [2*NUM_REQ-1:0] w_req_dbl;
  logic [2*NUM_REQ-1:0] w_req_shift;
  logic [NUM_REQ-1:0]   w_req_rot;
  logic [ID_W-1:0]      w_off;
  logic [SUM_W-1:0]     w_sum;
  logic [ID_W-1:0]      w_sel;
  logic [NUM_REQ-1:0]   w_sel_onehot;
  logic                 w_done_hit;
  logic                 w_hold_max;
  logic [ID_W-1:0]      w_ptr_adv;

  // Rotate requests so the pointer position sits at bit 0, then find the
  // lowest set bit; the rotated offset is mapped back modulo NUM_REQ.
  always_comb begin
    w_req_dbl   = {req, req};
    w_req_shift = w_req_dbl >> r_ptr;
    w_req_rot   = w_req_shift[NUM_REQ-1:0];
    w_off       = '0;
    for (int j = int'(NUM_REQ) - 1; j >= 0; j--) begin
      if (w_req_rot[j]) begin
        w_off = ID_W'(j);
      end
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= SUM_W'(NUM_REQ)) begin
      w_sel = ID_W'(w_sum - SUM_W'(NUM_REQ));
    end else begin
      w_sel = ID_W'(w_sum);
    end
    w_sel_onehot = NUM_REQ'(1) << w_sel;
  end

  // Release conditions; done from non-owners is masked by the one-hot grant.
  always_comb begin
    w_done_hit = |(done & r_gnt);
    w_hold_max = (r_cnt == CNT_W'(MAX_HOLD));
    w_ptr_adv  = (r_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : r_gnt_id + ID_W'(1);
  end

  // Next-state and registered-output values.
  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_gnt_id_nxt  = r_gnt_id;
    w_busy_nxt    = r_busy;
    w_timeout_nxt = 1'b0;
    w_cnt_nxt     = r_cnt;
    w_ptr_nxt     = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (en && (|req)) begin
          w_state_nxt  = ST_GRANT;
          w_gnt_nxt    = w_sel_onehot;
          w_gnt_id_nxt = w_sel;
          w_busy_nxt   = 1'b1;
          w_cnt_nxt    = CNT_W'(1);
        end else begin
          w_gnt_nxt  = '0;
          w_busy_nxt = 1'b0;
        end
      end
      ST_GRANT: begin
        if (w_done_hit || w_hold_max) begin
          // done takes priority over the hold limit: no timeout pulse then.
          w_state_nxt   = ST_IDLE;
          w_gnt_nxt     = '0;
          w_busy_nxt    = 1'b0;
          w_cnt_nxt     = '0;
          w_ptr_nxt     = w_ptr_adv;
          w_timeout_nxt = !w_done_hit;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_gnt     <= '0;
      r_gnt_id  <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
      r_ptr     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_gnt_id  <= w_gnt_id_nxt;
      r_busy    <= w_busy_nxt;
      r_timeout <= w_timeout_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ptr     <= w_ptr_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign gnt_id  = r_gnt_id;
  assign busy    = r_busy;
  assign timeout = r_timeout;

endmodule
